// File: rtl/v_registers_univ.sv
// Universal WIDTH-bit working register: hold, load, shift, rotate, increment, decrement.
// Optional synchronous clear input SCLR is enabled by defining V_REGISTERS_UNIV_SCLR_EN.
module v_registers_univ #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '1
) (
  input  logic             C,
  input  logic             PRE_N,
  input  logic             CE,
`ifdef V_REGISTERS_UNIV_SCLR_EN
  input  logic             SCLR,
`endif
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIR,
  input  logic             SIL,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             ZERO
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("v_registers_univ: WIDTH must be in 2..32");
  end

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_SHL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

  mode_e            mode;
  logic [WIDTH:0]   inc_res;
  logic [WIDTH:0]   dec_res;
  logic [WIDTH-1:0] q_nxt;
  logic             co_nxt;

  assign mode = mode_e'(MODE);

  // One extra bit on the arithmetic: its top bit is the carry (increment) or borrow (decrement).
  assign inc_res = {1'b0, Q} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_res = {1'b0, Q} - {{WIDTH{1'b0}}, 1'b1};

  // NOTE: defaults first so every path assigns q_nxt/co_nxt; otherwise a latch is inferred.
  always_comb begin
    q_nxt  = Q;
    co_nxt = CO;
    case (mode)
      MODE_HOLD: begin
        q_nxt  = Q;
        co_nxt = CO;
      end
      MODE_LOAD: begin
        q_nxt  = D;
        co_nxt = 1'b0;
      end
      MODE_SHR: begin
        q_nxt  = {SIR, Q[WIDTH-1:1]};
        co_nxt = Q[0];
      end
      MODE_SHL: begin
        q_nxt  = {Q[WIDTH-2:0], SIL};
        co_nxt = Q[WIDTH-1];
      end
      MODE_ROR: begin
        q_nxt  = {Q[0], Q[WIDTH-1:1]};
        co_nxt = Q[0];
      end
      MODE_ROL: begin
        q_nxt  = {Q[WIDTH-2:0], Q[WIDTH-1]};
        co_nxt = Q[WIDTH-1];
      end
      MODE_INC: begin
        q_nxt  = inc_res[WIDTH-1:0];
        co_nxt = inc_res[WIDTH];
      end
      MODE_DEC: begin
        q_nxt  = dec_res[WIDTH-1:0];
        co_nxt = dec_res[WIDTH];
      end
      default: begin
        q_nxt  = Q;
        co_nxt = CO;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge C or negedge PRE_N) begin
    if (!PRE_N) begin
      Q  <= INIT;
      CO <= 1'b0;
    end else
`ifdef V_REGISTERS_UNIV_SCLR_EN
    if (SCLR) begin
      Q  <= '0;
      CO <= 1'b0;
    end else
`endif
    if (CE) begin
      Q  <= q_nxt;
      CO <= co_nxt;
    end
  end

  assign ZERO = (Q == '0);

endmodule

// File: tb/tb_v_registers_univ.sv
// Directed self-checking bench for v_registers_univ (WIDTH=4 default INIT, WIDTH=8 INIT=0).
// SCLR steps run when V_REGISTERS_UNIV_SCLR_EN is defined for both files.
module tb_v_registers_univ;

  logic       c = 1'b0;
  logic       pre_n, ce, sir, sil;
  logic       pre_n8, ce8;
  logic [2:0] mode;
  logic [3:0] d;
  logic [7:0] d8;
  logic [3:0] q;
  logic       co, zero;
  logic [7:0] q8;
  logic       co8, zero8;
`ifdef V_REGISTERS_UNIV_SCLR_EN
  logic       sclr = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 c = ~c;

  v_registers_univ #(.WIDTH(4)) u_dut4 (
    .C(c), .PRE_N(pre_n), .CE(ce),
`ifdef V_REGISTERS_UNIV_SCLR_EN
    .SCLR(sclr),
`endif
    .MODE(mode), .D(d), .SIR(sir), .SIL(sil),
    .Q(q), .CO(co), .ZERO(zero)
  );

  v_registers_univ #(.WIDTH(8), .INIT(8'h00)) u_dut8 (
    .C(c), .PRE_N(pre_n8), .CE(ce8),
`ifdef V_REGISTERS_UNIV_SCLR_EN
    .SCLR(sclr),
`endif
    .MODE(mode), .D(d8), .SIR(sir), .SIL(sil),
    .Q(q8), .CO(co8), .ZERO(zero8)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic drive(input logic [2:0] m);
    @(negedge c);
    mode = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pre_n = 1'b1; ce = 1'b0; mode = 3'b000; d = 4'h0; sir = 1'b0; sil = 1'b0;
    pre_n8 = 1'b0; ce8 = 1'b0; d8 = 8'h00;
    repeat (2) @(posedge c);

    // Asynchronous reset mid-cycle, no clock edge in between
    @(negedge c);
    #2 pre_n = 1'b0;
    #1;
    check("rst_q", q, 4'hF);
    check("rst_co", co, 1'b0);
    check("rst_zero", zero, 1'b0);
    check("rst8_q", q8, 8'h00);
    check("rst8_zero", zero8, 1'b1);
    check("rst8_co", co8, 1'b0);

    // Reset dominates CE/MODE/D across several edges
    ce = 1'b1; mode = 3'b001; d = 4'b0101;
    repeat (3) tick();
    check("rst_hold_q", q, 4'hF);

    // Load then CE gating
    @(negedge c); pre_n = 1'b1; d = 4'b1010;
    tick();
    check("load_q", q, 4'b1010);
    check("load_co", co, 1'b0);
    @(negedge c); ce = 1'b0; mode = 3'b110;
    repeat (3) tick();
    check("ce_low_q", q, 4'b1010);
    check("ce_low_co", co, 1'b0);

    // Shifts
    @(negedge c); ce = 1'b1; mode = 3'b010; sir = 1'b1;
    tick();
    check("shr_q", q, 4'b1101);
    check("shr_co", co, 1'b0);
    @(negedge c); mode = 3'b011; sil = 1'b0;
    tick();
    check("shl_q", q, 4'b1010);
    check("shl_co", co, 1'b1);
    @(negedge c); mode = 3'b011; sil = 1'b1;
    tick();
    check("shl_sil_q", q, 4'b0101);
    check("shl_sil_co", co, 1'b1);

    // Rotates
    @(negedge c); mode = 3'b001; d = 4'b1001;
    tick();
    check("load2_co", co, 1'b0);
    drive(3'b100);
    tick();
    check("ror_q", q, 4'b1100);
    check("ror_co", co, 1'b1);
    drive(3'b101);
    tick();
    check("rol_q", q, 4'b1001);
    check("rol_co", co, 1'b1);

    // Counter wrap both ways
    @(negedge c); mode = 3'b001; d = 4'b1110;
    tick();
    drive(3'b110);
    tick();
    check("inc1_q", q, 4'b1111);
    check("inc1_co", co, 1'b0);
    tick();
    check("inc2_q", q, 4'b0000);
    check("inc2_co", co, 1'b1);
    check("inc2_zero", zero, 1'b1);
    drive(3'b111);
    tick();
    check("dec_wrap_q", q, 4'b1111);
    check("dec_wrap_co", co, 1'b1);
    check("dec_wrap_zero", zero, 1'b0);

    // Hold keeps CO; CE low keeps CO; non-wrapping decrement clears it
    drive(3'b000);
    tick();
    check("hold_q", q, 4'b1111);
    check("hold_co", co, 1'b1);
    @(negedge c); ce = 1'b0; mode = 3'b001; d = 4'h3;
    tick();
    check("ce_low_co1", co, 1'b1);
    check("ce_low_load_q", q, 4'b1111);
    @(negedge c); ce = 1'b1; mode = 3'b111;
    tick();
    check("dec_q", q, 4'b1110);
    check("dec_co", co, 1'b0);

`ifdef V_REGISTERS_UNIV_SCLR_EN
    // Synchronous clear beats CE low; reset beats clear
    @(negedge c); mode = 3'b001; d = 4'b0110;
    tick();
    @(negedge c); ce = 1'b0; sclr = 1'b1; mode = 3'b110;
    tick();
    check("sclr_q", q, 4'b0000);
    check("sclr_co", co, 1'b0);
    @(negedge c); pre_n = 1'b0;
    #1;
    check("sclr_rst_q", q, 4'hF);
    tick();
    check("sclr_rst_hold_q", q, 4'hF);
    @(negedge c); sclr = 1'b0; pre_n = 1'b1; ce = 1'b1;
`endif

    // Reset in the middle of counting discards state
    @(negedge c); mode = 3'b110;
    tick();
    #2 pre_n = 1'b0;
    #1;
    check("midrst_q", q, 4'hF);
    check("midrst_co", co, 1'b0);

    // WIDTH=8, INIT=0: increment wrap from 8'hFF
    @(negedge c); pre_n8 = 1'b1; ce8 = 1'b1; mode = 3'b001; d8 = 8'hFF;
    tick();
    check("w8_load_q", q8, 8'hFF);
    check("w8_load_zero", zero8, 1'b0);
    drive(3'b110);
    tick();
    check("w8_inc_q", q8, 8'h00);
    check("w8_inc_co", co8, 1'b1);
    check("w8_inc_zero", zero8, 1'b1);
    drive(3'b010);
    sir = 1'b1;
    tick();
    check("w8_shr_q", q8, 8'h80);
    check("w8_shr_co", co8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
